// File: rtl/shift_reg_credit_sink.sv
// ---------------------------------------------------------------------------
// shift_reg_credit_sink
//
// Receiving end of a fixed-latency, valid-only shift-register pipeline that
// has no backpressure. Upstream must obtain a credit (req_valid_i while
// req_ready_o) before it injects a beat into the pipeline. Arriving beats are
// buffered in a Depth-entry circular FIFO and presented on a valid/ready
// output stream. Every output pop returns one credit, so a well-behaved
// upstream can never overflow the buffer.
//
// Ports
//   clk_i        in   1      clock, all state updates on the rising edge
//   rst_i        in   1      asynchronous, active-high reset
//   req_valid_i  in   1      upstream wants to inject one beat
//   req_ready_o  out  1      credit available; grant = req_valid_i & req_ready_o
//   valid_i      in   1      beat arriving from the delay pipeline (no ready)
//   data_i       in   Width  arriving beat payload
//   valid_o      out  1      output beat available
//   ready_i      in   1      downstream accepts; pop = valid_o & ready_i
//   data_o       out  Width  head-of-FIFO payload
//   credits_o    out  CntW   current free credits
//   count_o      out  CntW   current FIFO occupancy
//   overflow_o   out  1      sticky: a beat was dropped because FIFO was full
//
// A mid-operation reset discards every credit, including credits for beats
// still travelling through the pipeline, so the pipeline must share rst_i.
// ---------------------------------------------------------------------------
module shift_reg_credit_sink #(
    parameter  int Depth = 8,
    parameter  int Width = 32,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  credits_o,
    output logic [CntW-1:0]  count_o,
    output logic             overflow_o
);

    // Pointer width; a single-entry FIFO still needs a 1-bit pointer.
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [CntW-1:0] DEPTH_C  = CntW'(Depth);
    localparam logic [CntW-1:0] CNT_ZERO = {CntW{1'b0}};
    localparam logic [CntW-1:0] CNT_ONE  = CntW'(1);
    localparam logic [PtrW-1:0] PTR_LAST = PtrW'(Depth - 1);
    localparam logic [PtrW-1:0] PTR_ZERO = {PtrW{1'b0}};
    localparam logic [PtrW-1:0] PTR_ONE  = PtrW'(1);

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic [CntW-1:0]  r_credits;
    logic             r_overflow;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic             w_grant;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;

    logic [PtrW-1:0]  w_wr_ptr_nxt;
    logic [PtrW-1:0]  w_rd_ptr_nxt;
    logic [CntW-1:0]  w_count_nxt;
    logic [CntW-1:0]  w_credits_nxt;
    logic             w_overflow_nxt;

    assign w_grant = req_valid_i & req_ready_o;
    assign w_pop   = valid_o & ready_i;
    assign w_full  = (r_count == DEPTH_C);
    // When full, a same-cycle pop frees the head slot; the head is read
    // combinationally before the write lands, so wr_ptr == rd_ptr is safe.
    assign w_push  = valid_i & (~w_full | w_pop);
    assign w_drop  = valid_i & w_full & ~w_pop;

    // Next-state computation for pointers, occupancy, credits and error flag.
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_credits_nxt  = r_credits;
        w_overflow_nxt = r_overflow;

        if (w_push) begin
            w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_pop) begin
            w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end

        // A grant needs a non-zero credit count, so decrement cannot
        // underflow; the increment is clamped at Depth against misuse.
        if (w_grant && !w_pop) begin
            w_credits_nxt = r_credits - CNT_ONE;
        end else if (w_pop && !w_grant && (r_credits != DEPTH_C)) begin
            w_credits_nxt = r_credits + CNT_ONE;
        end else begin
            w_credits_nxt = r_credits;
        end

        if (w_drop) begin
            w_overflow_nxt = 1'b1;
        end else begin
            w_overflow_nxt = r_overflow;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= PTR_ZERO;
            r_rd_ptr   <= PTR_ZERO;
            r_count    <= CNT_ZERO;
            r_credits  <= DEPTH_C;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_credits  <= w_credits_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Payload storage; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all derived directly from registered state
    // ------------------------------------------------------------------
    assign req_ready_o = (r_credits != CNT_ZERO);
    assign valid_o     = (r_count != CNT_ZERO);
    assign data_o      = r_mem[r_rd_ptr];
    assign credits_o   = r_credits;
    assign count_o     = r_count;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_shift_reg_credit_sink.sv
module tb_shift_reg_credit_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Depth=4 instance
    logic       rst4, rqv4, rqr4, vi4, vo4, ri4, ov4;
    logic [7:0] di4, do4;
    logic [2:0] cr4, cn4;

    // Depth=5 instance (non-power-of-2 wrap)
    logic       rst5, rqv5, rqr5, vi5, vo5, ri5, ov5;
    logic [7:0] di5, do5;
    logic [2:0] cr5, cn5;

    logic [7:0] q5[$];
    logic [7:0] exp5;

    shift_reg_credit_sink #(.Depth(4), .Width(8)) u_dut4 (
        .clk_i(clk), .rst_i(rst4), .req_valid_i(rqv4), .req_ready_o(rqr4),
        .valid_i(vi4), .data_i(di4), .valid_o(vo4), .ready_i(ri4),
        .data_o(do4), .credits_o(cr4), .count_o(cn4), .overflow_o(ov4)
    );

    shift_reg_credit_sink #(.Depth(5), .Width(8)) u_dut5 (
        .clk_i(clk), .rst_i(rst5), .req_valid_i(rqv5), .req_ready_o(rqr5),
        .valid_i(vi5), .data_i(di5), .valid_o(vo5), .ready_i(ri5),
        .data_o(do5), .credits_o(cr5), .count_o(cn5), .overflow_o(ov5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset4();
        rqv4 = 1'b0; vi4 = 1'b0; di4 = 8'h00; ri4 = 1'b0;
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
    endtask

    // Take 4 credits, then deliver 4 beats base..base+3 with ready_i low.
    task automatic fill4(input logic [7:0] base);
        ri4 = 1'b0;
        rqv4 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rqv4 = 1'b0;
        vi4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            di4 = base + 8'(i);
            tick();
        end
        vi4 = 1'b0;
    endtask

    task automatic test_reset();
        reset4();
        n_vec++; if (cr4 !== 3'd4) begin n_err++; $display("FAIL reset_credits act=%0d exp=4", cr4); end
        n_vec++; if (cn4 !== 3'd0) begin n_err++; $display("FAIL reset_count act=%0d exp=0", cn4); end
        n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL reset_valid act=%b exp=0", vo4); end
        n_vec++; if (rqr4 !== 1'b1) begin n_err++; $display("FAIL reset_req_ready act=%b exp=1", rqr4); end
        n_vec++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL reset_overflow act=%b exp=0", ov4); end
    endtask

    task automatic test_grants();
        logic [2:0] exp;
        reset4();
        rqv4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 3'(4 - i);
            n_vec++; if (cr4 !== exp) begin n_err++; $display("FAIL grant_credits[%0d] act=%0d exp=%0d", i, cr4, exp); end
            tick();
        end
        n_vec++; if (cr4 !== 3'd0) begin n_err++; $display("FAIL grant_credits_end act=%0d exp=0", cr4); end
        n_vec++; if (rqr4 !== 1'b0) begin n_err++; $display("FAIL grant_req_ready_end act=%b exp=0", rqr4); end
        tick();
        n_vec++; if (cr4 !== 3'd0) begin n_err++; $display("FAIL grant_no_underflow act=%0d exp=0", cr4); end
        rqv4 = 1'b0;
    endtask

    task automatic test_stream();
        reset4();
        rqv4 = 1'b1;
        tick(); tick(); tick();
        n_vec++; if (cr4 !== 3'd1) begin n_err++; $display("FAIL stream_credits_granted act=%0d exp=1", cr4); end
        rqv4 = 1'b0; ri4 = 1'b1;
        vi4 = 1'b1; di4 = 8'hA1; tick();
        n_vec++; if (vo4 !== 1'b1 || do4 !== 8'hA1) begin n_err++; $display("FAIL stream_a1 act=%b/%h exp=1/a1", vo4, do4); end
        n_vec++; if (cr4 !== 3'd1) begin n_err++; $display("FAIL stream_credits_a1 act=%0d exp=1", cr4); end
        di4 = 8'hA2; tick();
        n_vec++; if (vo4 !== 1'b1 || do4 !== 8'hA2) begin n_err++; $display("FAIL stream_a2 act=%b/%h exp=1/a2", vo4, do4); end
        n_vec++; if (cr4 !== 3'd2) begin n_err++; $display("FAIL stream_credits_a2 act=%0d exp=2", cr4); end
        di4 = 8'hA3; tick();
        n_vec++; if (vo4 !== 1'b1 || do4 !== 8'hA3) begin n_err++; $display("FAIL stream_a3 act=%b/%h exp=1/a3", vo4, do4); end
        vi4 = 1'b0; tick();
        n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL stream_empty act=%b exp=0", vo4); end
        n_vec++; if (cr4 !== 3'd4) begin n_err++; $display("FAIL stream_credits_back act=%0d exp=4", cr4); end
        ri4 = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hB1; exp_seq[1] = 8'hB2; exp_seq[2] = 8'hB3; exp_seq[3] = 8'hBB;
        reset4();
        fill4(8'hB0);
        n_vec++; if (cn4 !== 3'd4 || do4 !== 8'hB0) begin n_err++; $display("FAIL full_fill act=%0d/%h exp=4/b0", cn4, do4); end
        vi4 = 1'b1; di4 = 8'hBB; ri4 = 1'b1; tick();
        vi4 = 1'b0;
        n_vec++; if (cn4 !== 3'd4) begin n_err++; $display("FAIL full_pp_count act=%0d exp=4", cn4); end
        n_vec++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL full_pp_overflow act=%b exp=0", ov4); end
        n_vec++; if (cr4 !== 3'd1) begin n_err++; $display("FAIL full_pp_credits act=%0d exp=1", cr4); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (do4 !== exp_seq[i]) begin n_err++; $display("FAIL full_pp_drain[%0d] act=%h exp=%h", i, do4, exp_seq[i]); end
            tick();
        end
        n_vec++; if (cn4 !== 3'd0) begin n_err++; $display("FAIL full_pp_drained act=%0d exp=0", cn4); end
        ri4 = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hC0; exp_seq[1] = 8'hC1; exp_seq[2] = 8'hC2; exp_seq[3] = 8'hC3;
        reset4();
        fill4(8'hC0);
        vi4 = 1'b1; di4 = 8'hCC; ri4 = 1'b0; tick();
        vi4 = 1'b0;
        n_vec++; if (cn4 !== 3'd4) begin n_err++; $display("FAIL ovf_count act=%0d exp=4", cn4); end
        n_vec++; if (ov4 !== 1'b1) begin n_err++; $display("FAIL ovf_flag act=%b exp=1", ov4); end
        n_vec++; if (cr4 !== 3'd0) begin n_err++; $display("FAIL ovf_credits act=%0d exp=0", cr4); end
        ri4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (do4 !== exp_seq[i] || ov4 !== 1'b1) begin n_err++; $display("FAIL ovf_drain[%0d] act=%h/%b exp=%h/1", i, do4, ov4, exp_seq[i]); end
            tick();
        end
        n_vec++; if (vo4 !== 1'b0 || cr4 !== 3'd4) begin n_err++; $display("FAIL ovf_drained act=%b/%0d exp=0/4", vo4, cr4); end
        // Pop request on an empty FIFO must not mint a credit.
        tick();
        n_vec++; if (cr4 !== 3'd4 || cn4 !== 3'd0 || ov4 !== 1'b1) begin n_err++; $display("FAIL empty_pop act=%0d/%0d/%b exp=4/0/1", cr4, cn4, ov4); end
        ri4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        reset4();
        rqv4 = 1'b1; tick(); tick();
        rqv4 = 1'b0;
        vi4 = 1'b1; di4 = 8'hD0; tick(); di4 = 8'hD1; tick();
        vi4 = 1'b0;
        n_vec++; if (cr4 !== 3'd2 || cn4 !== 3'd2) begin n_err++; $display("FAIL b2b_pre act=%0d/%0d exp=2/2", cr4, cn4); end
        rqv4 = 1'b1; ri4 = 1'b1; tick();
        rqv4 = 1'b0; ri4 = 1'b0;
        n_vec++; if (cr4 !== 3'd2) begin n_err++; $display("FAIL b2b_credits act=%0d exp=2", cr4); end
        n_vec++; if (cn4 !== 3'd1 || do4 !== 8'hD1) begin n_err++; $display("FAIL b2b_head act=%0d/%h exp=1/d1", cn4, do4); end
    endtask

    task automatic test_async_reset();
        reset4();
        fill4(8'h60);
        vi4 = 1'b1; di4 = 8'h6F; tick();
        vi4 = 1'b0; ri4 = 1'b1; tick();
        ri4 = 1'b0;
        n_vec++; if (cn4 !== 3'd3 || ov4 !== 1'b1) begin n_err++; $display("FAIL arst_pre act=%0d/%b exp=3/1", cn4, ov4); end
        #2; rst4 = 1'b1; #1;
        n_vec++; if (vo4 !== 1'b0) begin n_err++; $display("FAIL arst_valid act=%b exp=0", vo4); end
        n_vec++; if (cr4 !== 3'd4) begin n_err++; $display("FAIL arst_credits act=%0d exp=4", cr4); end
        n_vec++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL arst_overflow act=%b exp=0", ov4); end
        n_vec++; if (cn4 !== 3'd0) begin n_err++; $display("FAIL arst_count act=%0d exp=0", cn4); end
        #1; rst4 = 1'b0;
    endtask

    task automatic test_wrap5();
        rqv5 = 1'b0; vi5 = 1'b0; di5 = 8'h00; ri5 = 1'b0;
        rst5 = 1'b1; tick(); rst5 = 1'b0;
        q5.delete();
        rqv5 = 1'b1; vi5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            di5 = 8'h50 + 8'(i);
            q5.push_back(di5);
            tick();
        end
        n_vec++; if (cn5 !== 3'd3 || cr5 !== 3'd2) begin n_err++; $display("FAIL wrap_fill act=%0d/%0d exp=3/2", cn5, cr5); end
        ri5 = 1'b1;
        for (int i = 3; i < 15; i++) begin
            di5 = 8'h50 + 8'(i);
            q5.push_back(di5);
            exp5 = q5[0];
            n_vec++; if (do5 !== exp5) begin n_err++; $display("FAIL wrap_stream[%0d] act=%h exp=%h", i, do5, exp5); end
            tick();
            void'(q5.pop_front());
        end
        n_vec++; if (cn5 !== 3'd3 || cr5 !== 3'd2) begin n_err++; $display("FAIL wrap_steady act=%0d/%0d exp=3/2", cn5, cr5); end
        rqv5 = 1'b0; vi5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp5 = q5[0];
            n_vec++; if (do5 !== exp5) begin n_err++; $display("FAIL wrap_drain[%0d] act=%h exp=%h", i, do5, exp5); end
            tick();
            void'(q5.pop_front());
        end
        n_vec++; if (vo5 !== 1'b0 || cr5 !== 3'd5) begin n_err++; $display("FAIL wrap_end act=%b/%0d exp=0/5", vo5, cr5); end
        ri5 = 1'b0;
    endtask

    initial begin
        rst4 = 1'b1; rst5 = 1'b1;
        rqv4 = 1'b0; vi4 = 1'b0; di4 = 8'h00; ri4 = 1'b0;
        rqv5 = 1'b0; vi5 = 1'b0; di5 = 8'h00; ri5 = 1'b0;
        #3;
        test_reset();
        test_grants();
        test_stream();
        test_full_push_pop();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_wrap5();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
